// File: rtl/ps2_kbd_tx_if.sv
// ps2_kbd_tx_if: byte handshake between a scan-code source and ps2_kbd_tx.
//   in_valid : source offers in_code this cycle
//   in_code  : scan-code byte
//   in_ready : transmitter FIFO has room; byte taken when in_valid & in_ready
// master = byte source, slave = ps2_kbd_tx.
`timescale 1ns/1ps
interface ps2_kbd_tx_if;
  logic       in_valid;
  logic [7:0] in_code;
  logic       in_ready;

  modport master (output in_valid, output in_code, input in_ready);
  modport slave  (input in_valid, input in_code, output in_ready);
endinterface

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: PS/2 device-side (keyboard end) transmitter.
// Scan-code bytes are buffered in a 2**FIFO_AW deep FIFO and sent as
// 11-bit frames {stop, odd parity, data[7:0], start}, LSB first.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   in_if (slave)   : in_valid / in_code / in_ready byte handshake
//   inject_perr     : only with PS2_TX_PARITY_ERR_EN; inverts the parity
//                     bit of the frame popped while it is high
//   ps2_clk         : PS/2 clock, idle high
//   ps2_data        : PS/2 data, idle high
//   busy            : frame (incl. gap) in progress or FIFO non-empty
//   overflow        : sticky, a byte was offered while the FIFO was full
// Optional feature macro: PS2_TX_PARITY_ERR_EN
`timescale 1ns/1ps
module ps2_kbd_tx #(
  parameter int CLK_HALF   = 4,
  parameter int GAP_CYCLES = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic         clk,
  input  logic         rst,
  ps2_kbd_tx_if.slave  in_if,
`ifdef PS2_TX_PARITY_ERR_EN
  input  logic         inject_perr,
`endif
  output logic         ps2_clk,
  output logic         ps2_data,
  output logic         busy,
  output logic         overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TMAX  = (CLK_HALF > GAP_CYCLES) ? CLK_HALF : GAP_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [10:0]      shreg_q, shreg_d;
  logic             ps2_clk_q, ps2_clk_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;

  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [DEPTH];
  logic             full, empty, push, pop;
  logic [7:0]       pop_code;
  logic             perr;
  logic [10:0]      frame;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                    (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  // full is judged on the current pointers, so a same-cycle pop never
  // frees a slot for a push.
  assign push     = in_if.in_valid && !full;
  assign pop_code = mem_q[rd_ptr_q[FIFO_AW-1:0]];

`ifdef PS2_TX_PARITY_ERR_EN
  assign perr = inject_perr;
`else
  assign perr = 1'b0;
`endif

  assign frame = {1'b1, (~^pop_code) ^ perr, pop_code, 1'b0};

  // ps2_data is the LSB of the shift register; it shifts in ones, so it
  // rests high once the stop bit has been shifted out.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ps2_clk_d = ps2_clk_q;
    pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        ps2_clk_d = 1'b1;
        shreg_d   = '1;
        if (!empty) pop = 1'b1;
      end
      BIT_HI: begin
        if (timer_q == TW'(CLK_HALF - 1)) begin
          timer_d   = '0;
          ps2_clk_d = 1'b0;
          state_d   = BIT_LO;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      BIT_LO: begin
        if (timer_q == TW'(CLK_HALF - 1)) begin
          timer_d   = '0;
          ps2_clk_d = 1'b1;
          shreg_d   = {1'b1, shreg_q[10:1]};
          if (bit_cnt_q < 4'd10) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            state_d   = BIT_HI;
          end else begin
            state_d = GAP;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GAP: begin
        if (timer_q == TW'(GAP_CYCLES - 1)) begin
          timer_d = '0;
          state_d = IDLE;
          // Start the next frame straight from the last gap cycle so
          // queued bytes are separated by exactly GAP_CYCLES.
          if (!empty) pop = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shreg_d   = frame;
      bit_cnt_d = '0;
      timer_d   = '0;
      ps2_clk_d = 1'b1;
      state_d   = BIT_HI;
    end

    wr_ptr_d   = wr_ptr_q + (FIFO_AW + 1)'(push);
    rd_ptr_d   = rd_ptr_q + (FIFO_AW + 1)'(pop);
    busy_d     = (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
    overflow_d = overflow_q || (in_if.in_valid && full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '1;
      ps2_clk_q  <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ps2_clk_q  <= ps2_clk_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= in_if.in_code;
  end

  assign in_if.in_ready = !full;
  assign ps2_clk        = ps2_clk_q;
  assign ps2_data       = shreg_q[0];
  assign busy           = busy_q;
  assign overflow       = overflow_q;

endmodule

// File: doc/ps2_kbd_tx.md
Name: ps2_kbd_tx

Overview:
- Synthesizable PS/2 device-side transmitter: emulates the keyboard end of the PS/2 link.
- Accepts scan-code bytes over a valid/ready interface and buffers them in a small FIFO.
- Serializes each byte as an 11-bit PS/2 frame on ps2_clk/ps2_data.
- Drives the existing ps2_keyboard receiver in simulation and on board, replacing the non-synthesizable behavioural keyboard model.

Parameters:
- CLK_HALF, 4: clk cycles per ps2_clk half-period; must be >= 2.
- GAP_CYCLES, 8: idle clk cycles, both lines high, after each stop bit; must be >= 1.
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  scan-code byte offered
- in_code  in  8  scan-code byte
- in_ready  out  1  FIFO not full; byte accepted when in_valid & in_ready at a clk edge
- ps2_clk  out  1  PS/2 clock, idle high
- ps2_data  out  1  PS/2 data, idle high
- busy  out  1  frame in progress (including gap) or FIFO non-empty
- overflow  out  1  sticky: a byte was offered while FIFO full

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. All outputs are registered.
- Reset values: ps2_clk=1, ps2_data=1, busy=0, overflow=0, in_ready=1; FIFO empty; FSM in IDLE.
- FIFO: push on in_valid & in_ready; in_ready = !full.
  - When full, push is refused even if a pop occurs in the same cycle.
  - in_valid & !in_ready sets overflow; the byte is dropped. overflow clears only on rst.
- Frame: shift register loaded with {stop=1, parity, in_code[7:0], start=0}, sent LSB first (11 bits).
  - parity = ~^code (odd parity: ones across data+parity is odd).
- FSM states:
  - IDLE: ps2_clk=1, ps2_data=1. If FIFO non-empty: pop, load shift register, bit_cnt=0, drive ps2_data=start bit, go to BIT_HI.
  - BIT_HI: ps2_clk=1, ps2_data=current bit, held CLK_HALF cycles, then go to BIT_LO.
  - BIT_LO: ps2_clk=0, data unchanged, held CLK_HALF cycles.
    - If bit_cnt<10: bit_cnt++, shift, present next bit, go to BIT_HI.
    - Else: ps2_data=1, go to GAP.
  - GAP: both lines high for GAP_CYCLES, then go to IDLE.
- Data only changes while ps2_clk is high. The receiver samples on the ps2_clk falling edge with a full CLK_HALF setup.
- Latency: byte accepted at edge N with FIFO empty and FSM in IDLE → popped at edge N+1, ps2_data=0 from N+1.
- Frame length: 22*CLK_HALF + GAP_CYCLES clk cycles, including gap. Back-to-back bytes start exactly GAP_CYCLES after the previous stop-bit low phase ends.
- Wrap-around: FIFO pointers are FIFO_AW+1 bits; full/empty are determined by MSB compare.
- Reset mid-frame: frame is aborted; lines return high on the next edge; FIFO is flushed.

Optional Feature:
- Macro: PS2_TX_PARITY_ERR_EN.
- When defined: adds input port inject_perr (1 bit).
  - The value is sampled at the pop and stored with the frame.
  - If 1, the transmitted parity bit is inverted for that frame only.
  - Used to exercise receiver error handling.
- When undefined: the port is absent and parity is always correct.

Test Plan:
- Reset then push 0x1C, CLK_HALF=4 → ps2_data low at N+1; bits 0,0,0,1,1,1,0,0,0,parity=0,stop=1; frame spans 88 clk + 8 gap; receiver reports data=0x1C, ready=1.
- Push 0x12, 0x1D, 0xF0 on consecutive cycles → three frames with exactly GAP_CYCLES high between them; receiver reads 0x12, 0x1D, 0xF0 in order; busy falls 1 cycle after the last gap.
- Parity edge values: 0x00 → parity 1; 0xFF → parity 1; 0x01 → parity 0; all accepted by the receiver without error.
- in_valid held 12 cycles with depth 8 → bytes 1–9 accepted (byte 1 popped at once), in_ready=0 from cycle 10, overflow=1; the 9 frames then arrive intact.
- Assert rst during bit 4 of a frame with 3 bytes queued → next edge ps2_clk=1, ps2_data=1, busy=0, overflow=0; no further frames.
- With PS2_TX_PARITY_ERR_EN, send 0x1C with inject_perr=1 → parity bit transmitted as 1; the following byte is sent with correct parity.
